mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter for the 5-stage RV32I core. It shares a single unified memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage), with at most one outstanding transaction. Responses are routed back to the requester that issued them. It sits inside `cpu`, between the pipeline memory interfaces and the unified instruction/data memory.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (IF / data) to one-port memory arbiter with a single outstanding transaction.
// Optional macro MEM_ARB_RR_EN selects round-robin tie-breaking; the default is fixed D-priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_resp_valid,
    output logic [DATA_WIDTH-1:0]   if_resp_rdata,
    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic                    d_req_we,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
    output logic                    d_resp_valid,
    output logic [DATA_WIDTH-1:0]   d_resp_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic                    mem_req_we,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_rdata
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_d_q, last_d_d;
    logic   hold_q, hold_d;
    logic   any_req;
    logic   grant_is_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_d_q <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_d_q <= last_d_d;
            hold_q   <= hold_d;
        end
    end

    // A stalled request keeps its grant so the fields seen by memory never change mid-offer.
    always_comb begin
        any_req = if_req_valid | d_req_valid;
        if (hold_q) begin
            grant_is_d = owner_q;
        end else begin
`ifdef MEM_ARB_RR_EN
            if (if_req_valid && d_req_valid)
                grant_is_d = ~last_d_q;
            else
                grant_is_d = d_req_valid;
`else
            grant_is_d = d_req_valid;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d_d = last_d_q;
        hold_d   = hold_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = grant_is_d;
                    if (mem_req_ready) begin
                        state_d  = BUSY;
                        last_d_d = grant_is_d;
                        hold_d   = 1'b0;
                    end else begin
                        hold_d   = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_resp_valid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;
        mem_req_valid = 1'b0;
        if_resp_valid = 1'b0;
        d_resp_valid  = 1'b0;
        if_resp_rdata = mem_resp_rdata;
        d_resp_rdata  = mem_resp_rdata;
        if (grant_is_d) begin
            mem_req_addr  = d_req_addr;
            mem_req_we    = d_req_we;
            mem_req_wdata = d_req_wdata;
            mem_req_wstrb = d_req_wstrb;
        end else begin
            mem_req_addr  = if_req_addr;
            mem_req_we    = 1'b0;
            mem_req_wdata = '0;
            mem_req_wstrb = '0;
        end
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    mem_req_valid = any_req;
                    if_req_ready  = if_req_valid & ~grant_is_d & mem_req_ready;
                    d_req_ready   = d_req_valid & grant_is_d & mem_req_ready;
                end
                BUSY: begin
                    if_resp_valid = mem_resp_valid & ~owner_q;
                    d_resp_valid  = mem_resp_valid & owner_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter; expectations follow MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam int RR = 1;
`else
    localparam int RR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [31:0] if_req_addr, if_resp_rdata;
    logic        d_req_valid, d_req_ready, d_req_we, d_resp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
    logic [3:0]  d_req_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    logic [3:0]  mem_req_wstrb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    typedef struct {
        logic [31:0] r, ifv, ifa, dv, da, dwe, dwd, dws, mrdy, mrv, mrd;
        logic [31:0] e_ifr, e_dr, e_mv, e_ma, e_mwe, e_mwd, e_mws, e_ifrv, e_drv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] r, ifv, ifa, dv, da, dwe, dwd, dws, mrdy, mrv, mrd,
                       input logic [31:0] e_ifr, e_dr, e_mv, e_ma, e_mwe, e_mwd, e_mws, e_ifrv, e_drv);
        vec_t v;
        v.r = r; v.ifv = ifv; v.ifa = ifa; v.dv = dv; v.da = da; v.dwe = dwe; v.dwd = dwd;
        v.dws = dws; v.mrdy = mrdy; v.mrv = mrv; v.mrd = mrd;
        v.e_ifr = e_ifr; v.e_dr = e_dr; v.e_mv = e_mv; v.e_ma = e_ma; v.e_mwe = e_mwe;
        v.e_mwd = e_mwd; v.e_mws = e_mws; v.e_ifrv = e_ifrv; v.e_drv = e_drv;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst            = v.r[0];
        if_req_valid   = v.ifv[0];
        if_req_addr    = v.ifa;
        d_req_valid    = v.dv[0];
        d_req_addr     = v.da;
        d_req_we       = v.dwe[0];
        d_req_wdata    = v.dwd;
        d_req_wstrb    = v.dws[3:0];
        mem_req_ready  = v.mrdy[0];
        mem_resp_valid = v.mrv[0];
        mem_resp_rdata = v.mrd;
    endtask

    task automatic idle_inputs();
        vec_t v;
        v = '{default: 32'h0};
        drive(v);
    endtask

    initial begin
        int accepts;
        int resps;
        int budget;
        bit seen;

        idle_inputs();
        rst = 1'b1;

        // reset state: outputs quiet even with every input active
        add(1, 1,'h10, 1,'h100,0,0,0, 1,1,'h11,   0,0,0,0,0,0,0, 0,0);
        add(1, 0,0,    0,0,0,0,0,     0,0,0,      0,0,0,0,0,0,0, 0,0);
        // data write
        add(0, 0,0,    1,'h100,1,'hDEADBEEF,'hF, 1,0,0,  0,1,1,'h100,1,'hDEADBEEF,'hF, 0,0);
        add(0, 0,0,    0,0,0,0,0,     0,1,'h0,    0,0,0,0,0,0,0, 0,1);
        // single IF read
        add(0, 1,'h10, 0,0,0,0,0,     1,0,0,      1,0,1,'h10,0,0,0, 0,0);
        add(0, 0,0,    0,0,0,0,0,     0,1,'h13,   0,0,0,0,0,0,0, 1,0);
        add(0, 0,0,    0,0,0,0,0,     0,0,0,      0,0,0,0,0,0,0, 0,0);
        // three ties in a row: fixed D,D,D / round-robin D,IF,D
        add(0, 1,'h4,  1,'h200,0,0,0, 1,0,0,      0,1,1,'h200,0,0,0, 0,0);
        add(0, 1,'h4,  1,'h200,0,0,0, 1,1,'h55,   0,0,0,0,0,0,0, 0,1);
        add(0, 1,'h4,  1,'h200,0,0,0, 1,0,0,      RR,1-RR,1,(RR != 0) ? 'h4 : 'h200,0,0,0, 0,0);
        add(0, 1,'h4,  1,'h200,0,0,0, 1,1,'h66,   0,0,0,0,0,0,0, RR,1-RR);
        add(0, 1,'h4,  1,'h200,0,0,0, 1,0,0,      0,1,1,'h200,0,0,0, 0,0);
        add(0, 0,0,    0,0,0,0,0,     0,1,'h67,   0,0,0,0,0,0,0, 0,1);
        // IF stalled for 3 cycles keeps its grant while D arrives
        add(0, 1,'h20, 0,0,0,0,0,     0,0,0,      0,0,1,'h20,0,0,0, 0,0);
        add(0, 1,'h20, 1,'h300,0,0,0, 0,0,0,      0,0,1,'h20,0,0,0, 0,0);
        add(0, 1,'h20, 1,'h300,0,0,0, 0,0,0,      0,0,1,'h20,0,0,0, 0,0);
        add(0, 1,'h20, 1,'h300,0,0,0, 1,0,0,      1,0,1,'h20,0,0,0, 0,0);
        add(0, 0,0,    1,'h300,0,0,0, 1,1,'h77,   0,0,0,0,0,0,0, 1,0);
        add(0, 0,0,    1,'h300,0,0,0, 1,0,0,      0,1,1,'h300,0,0,0, 0,0);
        add(0, 0,0,    0,0,0,0,0,     0,1,'h78,   0,0,0,0,0,0,0, 0,1);
        // reset while busy discards the late response
        add(0, 1,'h40, 0,0,0,0,0,     1,0,0,      1,0,1,'h40,0,0,0, 0,0);
        add(1, 0,0,    0,0,0,0,0,     0,0,0,      0,0,0,0,0,0,0, 0,0);
        add(0, 0,0,    0,0,0,0,0,     0,1,'h88,   0,0,0,0,0,0,0, 0,0);
        add(0, 0,0,    1,'h44,0,0,0,  1,0,0,      0,1,1,'h44,0,0,0, 0,0);
        add(0, 0,0,    0,0,0,0,0,     0,1,'h99,   0,0,0,0,0,0,0, 0,1);
        // spurious response in IDLE, then a normal request
        add(0, 0,0,    0,0,0,0,0,     0,1,'hAA,   0,0,0,0,0,0,0, 0,0);
        add(0, 1,'h50, 0,0,0,0,0,     1,0,0,      1,0,1,'h50,0,0,0, 0,0);
        add(0, 0,0,    0,0,0,0,0,     0,1,'hBB,   0,0,0,0,0,0,0, 1,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d ctl{ifr,dr,mv,ifrv,drv}", i),
                {if_req_ready, d_req_ready, mem_req_valid, if_resp_valid, d_resp_valid},
                {vecs[i].e_ifr[0], vecs[i].e_dr[0], vecs[i].e_mv[0], vecs[i].e_ifrv[0], vecs[i].e_drv[0]});
            chk($sformatf("v%0d rdata{if,d}", i), {if_resp_rdata, d_resp_rdata},
                {vecs[i].mrd, vecs[i].mrd});
            if (vecs[i].e_mv[0])
                chk($sformatf("v%0d mem{addr,we,wdata,wstrb}", i),
                    {mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb},
                    {vecs[i].e_ma, vecs[i].e_mwe[0], vecs[i].e_mwd, vecs[i].e_mws[3:0]});
        end

        // back-to-back IF reads with a next-cycle memory: one issue every 2 cycles
        accepts = 0;
        resps = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            idle_inputs();
            if_req_valid   = 1'b1;
            if_req_addr    = 32'(c * 4);
            mem_req_ready  = 1'b1;
            mem_resp_valid = c[0];
            mem_resp_rdata = 32'h1000 + 32'(c);
            #1;
            if (if_req_ready) accepts++;
            if (if_resp_valid) resps++;
        end
        chk("b2b accepts", 128'(accepts), 128'd4);
        chk("b2b responses", 128'(resps), 128'd4);

        // data read with a 3-cycle memory latency, waited on with a bounded budget
        @(negedge clk);
        idle_inputs();
        d_req_valid   = 1'b1;
        d_req_addr    = 32'h600;
        mem_req_ready = 1'b1;
        #1;
        chk("slow d accept", {d_req_ready, mem_req_addr}, {1'b1, 32'h600});
        seen = 1'b0;
        budget = 0;
        while (!seen && budget < 10) begin
            @(negedge clk);
            idle_inputs();
            mem_resp_valid = (budget == 2);
            mem_resp_rdata = 32'hC0FFEE00;
            #1;
            chk($sformatf("slow d wait%0d if_resp_valid", budget), 128'(if_resp_valid), 128'd0);
            if (d_resp_valid) begin
                seen = 1'b1;
                chk("slow d latency", 128'(budget), 128'd2);
                chk("slow d rdata", 128'(d_resp_rdata), 128'hC0FFEE00);
            end
            budget++;
        end
        chk("slow d response seen", 128'(seen), 128'd1);

        @(negedge clk);
        idle_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
